// File: rtl/riscv_pkg.sv
// Shared RV32I core constants: datapath width, result-select encodings and the x0 index.
// Used by control, the pipeline registers and the writeback stage.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_result_mux.sv
// 4:1 writeback result select. The reserved encoding yields zero so no X leaves the stage.
// Also instantiated by the forwarding unit.
module wb_result_mux
  import riscv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] alu_result,
  input  logic [W-1:0] read_data,
  input  logic [W-1:0] pc_plus4,
  output logic [W-1:0] result
);

  always_comb begin
    result = '0;
    case (sel)
      RESULT_ALU: result = alu_result;
      RESULT_MEM: result = read_data;
      RESULT_PC4: result = pc_plus4;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, architectural register file with write-through
// bypass to the two Decode read ports, and the retired-instruction counter.
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcW,
  input  logic [XLEN-1:0]  ALUResultW,
  input  logic [XLEN-1:0]  ReadDataW,
  input  logic [XLEN-1:0]  PCPlus4W,
  input  logic [XLEN-1:0]  InstrW,
  input  logic [4:0]       RdW,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  output logic [XLEN-1:0]  RD1D,
  output logic [XLEN-1:0]  RD2D,
  output logic [XLEN-1:0]  ResultW,
  output logic [CNT_W-1:0] InstretW
);

  logic             write_en;
  logic [XLEN-1:0]  rf_view [NREGS];
  logic [CNT_W-1:0] instret_reg;
  logic [CNT_W-1:0] instret_next;

  wb_result_mux #(.W(XLEN)) u_result_mux (
    .sel        (ResultSrcW),
    .alu_result (ALUResultW),
    .read_data  (ReadDataW),
    .pc_plus4   (PCPlus4W),
    .result     (ResultW)
  );

  // Gating by reset also disables the bypass, so reads during reset show storage.
  assign write_en = RegWriteW && (RdW != REG_ZERO) && !reset;

  // x0 has no storage; the remaining registers each get their own flop bank.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign rf_view[gi] = '0;
      end else begin : g_store
        logic [XLEN-1:0] q_reg;
        always_ff @(posedge clk) begin
          if (reset) begin
            q_reg <= '0;
          end else if (write_en && (RdW == 5'(gi))) begin
            q_reg <= ResultW;
          end
        end
        assign rf_view[gi] = q_reg;
      end
    end
  endgenerate

  always_comb begin
    RD1D = rf_view[Rs1D];
    if (write_en && (RdW == Rs1D)) begin
      RD1D = ResultW;
    end
  end

  always_comb begin
    RD2D = rf_view[Rs2D];
    if (write_en && (RdW == Rs2D)) begin
      RD2D = ResultW;
    end
  end

  // Any non-zero instruction word retires, including stores and branches.
  always_comb begin
    instret_next = instret_reg;
    if (InstrW != '0) begin
      instret_next = instret_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_reg <= '0;
    end else begin
      instret_reg <= instret_next;
    end
  end

  assign InstretW = instret_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expectations go into a scoreboard queue as each
// step is driven and are popped against the DUT outputs.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W, InstrW;
  logic [4:0]  RdW, Rs1D, Rs2D;
  logic [31:0] RD1D, RD2D, ResultW;
  logic [63:0] InstretW;

  // Narrow-counter instance used to reach the all-ones counter value quickly.
  logic [31:0] instr_s;
  logic [31:0] s_rd1, s_rd2, s_res;
  logic [3:0]  s_instret;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .InstrW(InstrW), .RdW(RdW), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW), .InstretW(InstretW)
  );

  wb_regfile #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .InstrW(instr_s), .RdW(RdW), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RD1D(s_rd1), .RD2D(s_rd2), .ResultW(s_res), .InstretW(s_instret)
  );

  task automatic push(input string tag, input logic [63:0] e);
    sb.push_back('{tag, e});
  endtask

  task automatic pop_check(input logic [63:0] obs);
    exp_t x;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h with no expected value", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
      end
      $display("vector %0d %s observed %h expected %h", vectors, x.tag, obs, x.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWriteW = 1'b0; ResultSrcW = 2'b00; ALUResultW = '0; ReadDataW = '0;
    PCPlus4W = '0; InstrW = '0; RdW = '0; Rs1D = '0; Rs2D = '0; instr_s = '0;
  endtask

  logic [31:0] sel_tbl [4];

  initial begin
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;

    // Every index reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      Rs1D = 5'(i);
      Rs2D = 5'(31 - i);
      #1;
      push($sformatf("rst_rd1_x%0d", i), 64'd0);
      push($sformatf("rst_rd2_x%0d", 31 - i), 64'd0);
      pop_check({32'd0, RD1D});
      pop_check({32'd0, RD2D});
    end
    push("rst_instret", 64'd0);
    pop_check(InstretW);

    // Result-select matrix.
    sel_tbl[0] = 32'h11111111; sel_tbl[1] = 32'h22222222;
    sel_tbl[2] = 32'h00000104; sel_tbl[3] = 32'h00000000;
    ALUResultW = 32'h11111111; ReadDataW = 32'h22222222; PCPlus4W = 32'h00000104;
    for (int s = 0; s < 4; s++) begin
      ResultSrcW = 2'(s);
      #1;
      push($sformatf("resultsel_%0d", s), {32'd0, sel_tbl[s]});
      pop_check({32'd0, ResultW});
    end

    // Write x5 from load data with same-cycle bypass on both ports.
    RegWriteW = 1'b1; RdW = 5'd5; ResultSrcW = 2'b01; ReadDataW = 32'hDEADBEEF;
    Rs1D = 5'd5; Rs2D = 5'd5;
    #1;
    push("bypass_rd1_x5", 64'h00000000DEADBEEF);
    push("bypass_rd2_x5", 64'h00000000DEADBEEF);
    pop_check({32'd0, RD1D});
    pop_check({32'd0, RD2D});
    step();
    RegWriteW = 1'b0; ReadDataW = 32'h0;
    #1;
    push("stored_rd1_x5", 64'h00000000DEADBEEF);
    push("stored_rd2_x5", 64'h00000000DEADBEEF);
    pop_check({32'd0, RD1D});
    pop_check({32'd0, RD2D});

    // Write x31 with PC+4: port 1 bypasses, port 2 reads stored x5.
    RegWriteW = 1'b1; RdW = 5'd31; ResultSrcW = 2'b10; PCPlus4W = 32'h00000200;
    Rs1D = 5'd31; Rs2D = 5'd5;
    #1;
    push("bypass_rd1_x31", 64'h0000000000000200);
    push("stored_rd2_x5_mixed", 64'h00000000DEADBEEF);
    pop_check({32'd0, RD1D});
    pop_check({32'd0, RD2D});
    step();
    RegWriteW = 1'b0; Rs2D = 5'd31;
    #1;
    push("stored_rd2_x31", 64'h0000000000000200);
    pop_check({32'd0, RD2D});

    // Writes to x0 are discarded and never bypassed.
    RegWriteW = 1'b1; RdW = 5'd0; ResultSrcW = 2'b00; ALUResultW = 32'hFFFFFFFF;
    Rs1D = 5'd0; Rs2D = 5'd0;
    #1;
    push("x0_same_cycle", 64'd0);
    pop_check({32'd0, RD1D});
    step();
    RegWriteW = 1'b0;
    #1;
    push("x0_next_cycle", 64'd0);
    pop_check({32'd0, RD1D});

    // Retire counting: a fresh reset gives a clean base.
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    InstrW = 32'h00000013;
    for (int c = 0; c < 10; c++) step();
    InstrW = 32'h0;
    for (int c = 0; c < 3; c++) step();
    InstrW = 32'h00A12023; RegWriteW = 1'b0;
    for (int c = 0; c < 2; c++) step();
    InstrW = 32'h0;
    push("instret_12", 64'd12);
    pop_check(InstretW);

    // Preload x7, then reset while a write to x7 is in flight.
    RegWriteW = 1'b1; RdW = 5'd7; ResultSrcW = 2'b00; ALUResultW = 32'h00000099;
    step();
    reset = 1'b1; ALUResultW = 32'h00000055; InstrW = 32'h00000013;
    Rs1D = 5'd7; Rs2D = 5'd7;
    #1;
    push("reset_no_bypass_rd1", 64'h0000000000000099);
    push("reset_resultw_comb", 64'h0000000000000055);
    pop_check({32'd0, RD1D});
    pop_check({32'd0, ResultW});
    step();
    reset = 1'b0; RegWriteW = 1'b0; InstrW = 32'h0;
    #1;
    push("x7_after_reset", 64'd0);
    push("instret_after_reset", 64'd0);
    pop_check({32'd0, RD1D});
    pop_check(InstretW);

    // Counter wrap on the 4-bit instance: drive to all ones, then retire one more.
    instr_s = 32'h00000013;
    for (int c = 0; c < 15; c++) step();
    push("narrow_instret_max", 64'd15);
    pop_check({60'd0, s_instret});
    step();
    instr_s = 32'h0;
    push("narrow_instret_wrap", 64'd0);
    pop_check({60'd0, s_instret});
    push("wide_instret_idle", 64'd0);
    pop_check(InstretW);

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
